load_store_unit: RTL and testbench

//  Parametrised data-memory access unit for the MEM stage of the Mips pipeline.

---
 rtl/load_store_unit_pkg.sv | 30 +++
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit_lane_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// lsu_defs: shared definitions for the load/store unit.
//   - Access-size encodings (byte / half / word; 2'b11 behaves as word).
//   - FSM state encoding for the request sequencer.
//   - is_misaligned(): natural-alignment test used by the lane aligner.
// Optional feature macro used elsewhere in the unit: MISALIGN_TRAP_EN.
package lsu_defs;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_t;

  // Bytes are always aligned; halves need addr[0]=0; words (and the
  // reserved size, which acts as a word) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      default:   mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response bundle between the MEM stage and
// the load/store unit.
//   master (pipeline side): drives req_valid, req_write, req_size,
//     req_unsigned, req_addr, req_wdata; observes req_ready, rsp_valid,
//     rsp_rdata, rsp_err, busy.
//   slave (load_store_unit): the mirror image.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: combinational little-endian lane steering.
//   size, offset   access size and addr[1:0]
//   is_unsigned    zero-extend (1) or sign-extend (0) loads
//   wdata          right-justified store data
//   raw_word       word read from the array
//   byte_en        lanes written by a store
//   wr_word        store data replicated onto every candidate lane
//   ld_data        selected lane, right-justified and extended
//   misalign       access violates natural alignment
// The offset is always force-aligned here; when misaligned accesses are
// trapped (MISALIGN_TRAP_EN) the top level squashes them, so the aligned
// lanes computed for them are never used.
module lsu_lane_align
  import lsu_defs::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign misalign = is_misaligned(size, offset);

  always_comb begin
    case (size)
      SIZE_BYTE: lane = offset;
      SIZE_HALF: lane = {offset[1], 1'b0};
      default:   lane = 2'b00;
    endcase
  end

  assign ld_byte = raw_word[8*lane +: 8];
  assign ld_half = lane[1] ? raw_word[31:16] : raw_word[15:0];

  always_comb begin
    case (size)
      SIZE_BYTE: begin
        byte_en = 4'b0001 << lane;
        wr_word = {4{wdata[7:0]}};
        ld_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
      end
      SIZE_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata[15:0]}};
        ld_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
      end
      default: begin
        byte_en = 4'b1111;
        wr_word = wdata;
        ld_data = raw_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage data memory with byte/half/word access and a
// programmable number of wait states.
//   clock, reset   single clock; synchronous active-high reset
//   bus (slave)    valid/ready request, one-cycle rsp_valid pulse with
//                  extended load data and misalign flag, busy stall output
// Parameters: ADDR_WIDTH (byte address width), DEPTH (32-bit words, power
// of two >= 4), WAIT_CYCLES (extra wait states, 0 allowed).
// Macro MISALIGN_TRAP_EN: when defined, misaligned accesses complete with
// rsp_err=1, rdata=0 and no write; otherwise they are force-aligned.
//
// Timing: the accept edge moves IDLE->BUSY (or straight to RESP when
// WAIT_CYCLES==0). BUSY lasts WAIT_CYCLES cycles. The edge that enters RESP
// commits stores and registers the array read; RESP always returns to IDLE.
module load_store_unit
  import lsu_defs::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LOW_W = IDX_W + 2;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ready_reg;
  logic              busy_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic [31:0]       rdata_hold_reg;

  logic              cap_write_reg;
  logic [1:0]        cap_size_reg;
  logic              cap_unsigned_reg;
  logic [LOW_W-1:0]  cap_addr_reg;
  logic [31:0]       cap_wdata_reg;

  logic [ADDR_WIDTH-1:0] addr_in;
  logic              in_idle;
  logic              eff_write;
  logic [1:0]        eff_size;
  logic              eff_unsigned;
  logic [LOW_W-1:0]  eff_addr;
  logic [31:0]       eff_wdata;
  logic [IDX_W-1:0]  eff_idx;

  logic [3:0]        byte_en;
  logic [31:0]       wr_word;
  logic [31:0]       ld_data;
  logic              misalign;
  logic [31:0]       ram_q;
  logic              trap_hit;
  logic              enter_resp;
  logic              commit_we;
  logic [31:0]       rdata_now;

  assign addr_in = bus.req_addr;

  // Address bits above the array wrap around and are deliberately dropped.
  if (ADDR_WIDTH > LOW_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_in[ADDR_WIDTH-1:LOW_W];
  end

  // With zero wait states the commit edge is the accept edge itself, so the
  // datapath must see the live request while idle and the captured copy after.
  assign in_idle      = (state_reg == ST_IDLE);
  assign eff_write    = in_idle ? bus.req_write    : cap_write_reg;
  assign eff_size     = in_idle ? bus.req_size     : cap_size_reg;
  assign eff_unsigned = in_idle ? bus.req_unsigned : cap_unsigned_reg;
  assign eff_addr     = in_idle ? addr_in[LOW_W-1:0] : cap_addr_reg;
  assign eff_wdata    = in_idle ? bus.req_wdata    : cap_wdata_reg;
  assign eff_idx      = eff_addr[LOW_W-1:2];

  lsu_lane_align u_align (
    .size        (eff_size),
    .offset      (eff_addr[1:0]),
    .is_unsigned (eff_unsigned),
    .wdata       (eff_wdata),
    .raw_word    (ram_q),
    .byte_en     (byte_en),
    .wr_word     (wr_word),
    .ld_data     (ld_data),
    .misalign    (misalign)
  );

  assign trap_hit   = TRAP_EN & misalign;
  assign enter_resp = (in_idle & bus.req_valid & (WAIT_CYCLES == 0))
                    | ((state_reg == ST_BUSY) & (cnt_reg == CNT_LAST));
  // Reset on the commit edge wins over the write.
  assign commit_we  = enter_resp & eff_write & ~trap_hit & ~reset;

  // One narrow array per byte lane so each lane has its own write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;
    always_ff @(posedge clock) begin
      if (enter_resp) begin
        q_reg <= mem[eff_idx];
      end
      if (commit_we && byte_en[gi]) begin
        mem[eff_idx] <= wr_word[8*gi +: 8];
      end
    end
    assign ram_q[8*gi +: 8] = q_reg;
  end

  // Valid only in RESP, where the aligner is driven by the captured request.
  assign rdata_now = (cap_write_reg | trap_hit) ? 32'd0 : ld_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      ready_reg        <= 1'b1;
      busy_reg         <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      rsp_err_reg      <= 1'b0;
      rdata_hold_reg   <= '0;
      cap_write_reg    <= 1'b0;
      cap_size_reg     <= SIZE_BYTE;
      cap_unsigned_reg <= 1'b0;
      cap_addr_reg     <= '0;
      cap_wdata_reg    <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.req_valid) begin
            cap_write_reg    <= bus.req_write;
            cap_size_reg     <= bus.req_size;
            cap_unsigned_reg <= bus.req_unsigned;
            cap_addr_reg     <= addr_in[LOW_W-1:0];
            cap_wdata_reg    <= bus.req_wdata;
            ready_reg        <= 1'b0;
            busy_reg         <= 1'b1;
            cnt_reg          <= '0;
            if (WAIT_CYCLES == 0) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= trap_hit;
            end else begin
              state_reg <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= trap_hit;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_reg      <= ST_IDLE;
          ready_reg      <= 1'b1;
          busy_reg       <= 1'b0;
          rsp_err_reg    <= 1'b0;
          rdata_hold_reg <= rdata_now;
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_reg;
  assign bus.busy      = busy_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_rdata = (state_reg == ST_RESP) ? rdata_now : rdata_hold_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance share the request fields; t_fast selects which one gets
// req_valid and whose outputs are observed. Expected responses are queued
// when a request is driven and popped when rsp_valid appears.
// Expectations for misaligned accesses follow MISALIGN_TRAP_EN.
module tb_load_store_unit;
  import lsu_defs::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  logic        t_fast;
  logic        t_valid;
  logic        t_write;
  logic [1:0]  t_size;
  logic        t_unsigned;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;

  int   vectors;
  int   miscompares;
  int   cyc;
  exp_t exp_q[$];

  load_store_unit_if #(.ADDR_WIDTH(32)) bus2 ();
  load_store_unit_if #(.ADDR_WIDTH(32)) bus0 ();

  load_store_unit #(.ADDR_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus2)
  );

  load_store_unit #(.ADDR_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(0)) dut_fast (
    .clock (clk),
    .reset (rst),
    .bus   (bus0)
  );

  assign bus2.req_valid    = t_valid & ~t_fast;
  assign bus0.req_valid    = t_valid & t_fast;
  assign bus2.req_write    = t_write;
  assign bus0.req_write    = t_write;
  assign bus2.req_size     = t_size;
  assign bus0.req_size     = t_size;
  assign bus2.req_unsigned = t_unsigned;
  assign bus0.req_unsigned = t_unsigned;
  assign bus2.req_addr     = t_addr;
  assign bus0.req_addr     = t_addr;
  assign bus2.req_wdata    = t_wdata;
  assign bus0.req_wdata    = t_wdata;

  logic        o_ready, o_busy, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  assign o_ready     = t_fast ? bus0.req_ready : bus2.req_ready;
  assign o_busy      = t_fast ? bus0.busy      : bus2.busy;
  assign o_rsp_valid = t_fast ? bus0.rsp_valid : bus2.rsp_valid;
  assign o_rsp_err   = t_fast ? bus0.rsp_err   : bus2.rsp_err;
  assign o_rsp_rdata = t_fast ? bus0.rsp_rdata : bus2.rsp_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One complete transaction: drive, wait for accept, wait for response,
  // compare latency, data and error flag against the queued expectation.
  task automatic access(input bit fast, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err,
                        input string name, output int acc_cycle);
    exp_t e;
    int   n;
    int   lat;
    int   exp_lat;
    e.rdata = exp_rd;
    e.err   = exp_err;
    exp_q.push_back(e);
    exp_lat = fast ? 1 : 3;
    @(negedge clk);
    t_fast = fast; t_write = wr; t_size = sz; t_unsigned = uns;
    t_addr = addr; t_wdata = wd; t_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc_cycle = cyc + 1;
    if (!o_ready) begin
      vectors++; miscompares++;
      $display("FAIL %s accept: req_ready=%0b after %0d cycles, required 1", name, o_ready, n);
      t_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(negedge clk);
    t_valid = 1'b0;
    vectors++;
    if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s post-accept: busy=%0b ready=%0b, required busy=1 ready=0", name, o_busy, o_ready);
    end
    lat = 1;
    while (!o_rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, exp_lat);
    end
    if (o_rsp_valid) begin
      vectors++;
      if (o_rsp_rdata !== e.rdata || o_rsp_err !== e.err) begin
        miscompares++;
        $display("FAIL %s response: rdata=%h err=%0b, required rdata=%h err=%0b",
                 name, o_rsp_rdata, o_rsp_err, e.rdata, e.err);
      end
    end
    $display("txn %-10s fast=%0b wr=%0b size=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             name, fast, wr, sz, addr, wd, o_rsp_rdata, o_rsp_err, lat);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    t_fast = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0b, required 1", o_ready); end
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b, required 0", o_busy); end
    vectors++;
    if (o_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %0b, required 0", o_rsp_valid); end
    vectors++;
    if (o_rsp_rdata !== 32'd0 || o_rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rsp: rdata=%h err=%0b, required 0/0", o_rsp_rdata, o_rsp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_word;
    int c;
    access(0, 1, SIZE_WORD, 0, 32'h08, 32'h11223344, 32'h0, 0, "sw_08", c);
    access(0, 0, SIZE_WORD, 0, 32'h08, 32'h0, 32'h11223344, 0, "lw_08", c);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'h11223344) begin
      miscompares++;
      $display("FAIL rdata_hold: valid=%0b rdata=%h, required 0/11223344", o_rsp_valid, o_rsp_rdata);
    end
  endtask

  task automatic test_sign_ext;
    int c;
    access(0, 1, SIZE_WORD, 0, 32'h0C, 32'h80FF7F01, 32'h0, 0, "sw_0c", c);
    access(0, 0, SIZE_BYTE, 0, 32'h0D, 32'h0, 32'h0000007F, 0, "lb_0d", c);
    access(0, 0, SIZE_BYTE, 0, 32'h0E, 32'h0, 32'hFFFFFFFF, 0, "lb_0e", c);
    access(0, 0, SIZE_BYTE, 1, 32'h0F, 32'h0, 32'h00000080, 0, "lbu_0f", c);
    access(0, 0, SIZE_HALF, 0, 32'h0E, 32'h0, 32'hFFFF80FF, 0, "lh_0e", c);
    access(0, 0, SIZE_HALF, 1, 32'h0C, 32'h0, 32'h00007F01, 0, "lhu_0c", c);
  endtask

  task automatic test_partial_store;
    int c;
    access(0, 1, SIZE_BYTE, 0, 32'h09, 32'hFFFFFFAB, 32'h0, 0, "sb_09", c);
    access(0, 0, SIZE_WORD, 0, 32'h08, 32'h0, 32'h1122AB44, 0, "lw_08b", c);
    access(0, 1, SIZE_HALF, 0, 32'h0A, 32'h1234BEEF, 32'h0, 0, "sh_0a", c);
    access(0, 0, SIZE_WORD, 0, 32'h08, 32'h0, 32'hBEEFAB44, 0, "lw_08h", c);
  endtask

  task automatic test_misalign;
    int c;
    access(0, 1, SIZE_WORD, 0, 32'h04, 32'hCAFEF00D, 32'h0, 0, "sw_04", c);
`ifdef MISALIGN_TRAP_EN
    access(0, 0, SIZE_WORD, 0, 32'h06, 32'h0, 32'h0, 1, "lw_06", c);
    access(0, 1, SIZE_HALF, 0, 32'h07, 32'h00005555, 32'h0, 1, "sh_07", c);
    access(0, 0, SIZE_WORD, 0, 32'h04, 32'h0, 32'hCAFEF00D, 0, "lw_04", c);
    access(0, 0, SIZE_HALF, 0, 32'h05, 32'h0, 32'h0, 1, "lh_05", c);
`else
    access(0, 0, SIZE_WORD, 0, 32'h06, 32'h0, 32'hCAFEF00D, 0, "lw_06", c);
    access(0, 1, SIZE_HALF, 0, 32'h07, 32'h00005555, 32'h0, 0, "sh_07", c);
    access(0, 0, SIZE_WORD, 0, 32'h04, 32'h0, 32'h5555F00D, 0, "lw_04", c);
    access(0, 0, SIZE_HALF, 0, 32'h05, 32'h0, 32'hFFFFF00D, 0, "lh_05", c);
`endif
  endtask

  task automatic test_back_to_back;
    int c1, c2, c3;
    access(1, 1, SIZE_WORD, 0, 32'h400, 32'hA5A50001, 32'h0, 0, "f_sw_400", c1);
    access(1, 0, SIZE_WORD, 0, 32'h000, 32'h0, 32'hA5A50001, 0, "f_lw_000", c2);
    access(1, 0, SIZE_BYTE, 1, 32'h803, 32'h0, 32'h000000A5, 0, "f_lbu_803", c3);
    vectors++;
    if (c2 - c1 !== 2 || c3 - c2 !== 2) begin
      miscompares++;
      $display("FAIL fast_throughput: accept spacing %0d,%0d, required 2,2", c2 - c1, c3 - c2);
    end
    access(0, 0, SIZE_WORD, 0, 32'h08, 32'h0, 32'hBEEFAB44, 0, "s_lw_a", c1);
    access(0, 0, SIZE_WORD, 0, 32'h0C, 32'h0, 32'h80FF7F01, 0, "s_lw_b", c2);
    vectors++;
    if (c2 - c1 !== 4) begin
      miscompares++;
      $display("FAIL slow_throughput: accept spacing %0d, required 4", c2 - c1);
    end
  endtask

  task automatic test_reset_abort;
    int c;
    logic seen;
    access(0, 1, SIZE_WORD, 0, 32'h10, 32'h01020304, 32'h0, 0, "sw_10", c);
    // Reset one cycle after the store is accepted.
    @(negedge clk);
    t_fast = 1'b0; t_write = 1'b1; t_size = SIZE_WORD; t_unsigned = 1'b0;
    t_addr = 32'h10; t_wdata = 32'hDEADBEEF; t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_rsp_valid !== 1'b0 ||
        o_rsp_rdata !== 32'd0 || o_rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_outputs: ready=%0b busy=%0b valid=%0b rdata=%h err=%0b, required 1/0/0/0/0",
               o_ready, o_busy, o_rsp_valid, o_rsp_rdata, o_rsp_err);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_rsp_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_rsp: rsp_valid seen=%0b, required 0", seen);
    end
    access(0, 0, SIZE_WORD, 0, 32'h10, 32'h0, 32'h01020304, 0, "lw_10a", c);
    // Reset exactly on the commit edge.
    @(negedge clk);
    t_write = 1'b1; t_size = SIZE_WORD; t_addr = 32'h10; t_wdata = 32'hDEADBEEF; t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_reset: valid=%0b ready=%0b, required 0/1", o_rsp_valid, o_ready);
    end
    rst = 1'b0;
    access(0, 0, SIZE_WORD, 0, 32'h10, 32'h0, 32'h01020304, 0, "lw_10b", c);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; t_fast = 1'b0; t_valid = 1'b0; t_write = 1'b0;
    t_size = SIZE_WORD; t_unsigned = 1'b0; t_addr = '0; t_wdata = '0;
    test_reset();
    test_word();
    test_sign_ext();
    test_partial_store();
    test_misalign();
    test_back_to_back();
    test_reset_abort();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
